bus_dma: RTL and testbench

- Parametrised multi-channel DMA engine for the CPU16-class memory bus.
- Arbitrates NUM_CH copy requests round-robin and takes the bus with the CPU's hold/busy handshake.
- Copies words memory-to-memory over the CPU's address/dataIn/dataOut/write bus; the top level muxes between CPU and DMA.
- Releases the bus periodically so the CPU is never starved.

---
 rtl/cpu16_bus_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/bus_dma.sv | 146 ++++++++++++++
 tb/tb_bus_dma.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_bus_pkg.sv
// Shared bus defaults and DMA state encoding for the CPU16-class memory bus.
package cpu16_bus_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefLenWidth  = 8;
  localparam int unsigned DefNumCh     = 4;
  localparam int unsigned DefBurst     = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_READ    = 3'd2,
    S_LATCH   = 3'd3,
    S_WRITE   = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after ptr.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        ptr,
  output logic [2:0]        grant,
  output logic              found
);

  logic [7:0]  req_pad;
  int unsigned idx;

  assign req_pad = 8'(req);

  always_comb begin
    grant = 3'd0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(ptr) + i) % NUM_CH;
      if (!found && req_pad[idx[2:0]]) begin
        found = 1'b1;
        grant = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/bus_dma.sv
// Multi-channel memory-to-memory DMA that borrows the CPU bus via hold/busy and
// gives it back every BURST words so the CPU is never starved.
module bus_dma
  import cpu16_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned LEN_WIDTH  = DefLenWidth,
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned BURST      = DefBurst
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_src,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_dst,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len,
  output logic [NUM_CH-1:0]            ch_done,
  output logic                         cpu_hold,
  input  logic                         cpu_busy,
  output logic                         bus_own,
  output logic [ADDR_WIDTH-1:0]        address,
  input  logic [DATA_WIDTH-1:0]        dataIn,
  output logic [DATA_WIDTH-1:0]        dataOut,
  output logic                         write,
  output logic [2:0]                   active_ch
);

  localparam int unsigned BurstW = $clog2(BURST + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [BurstW-1:0]     burst_q, burst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            active_q, active_d, rr_q, rr_d;

  logic [2:0]            grant;
  logic                  found;
  logic [ADDR_WIDTH-1:0] sel_src, sel_dst;
  logic [LEN_WIDTH-1:0]  sel_len;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req  (ch_req),
    .ptr  (rr_q),
    .grant(grant),
    .found(found)
  );

  assign sel_src = ch_src[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_dst = ch_dst[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_len = ch_len[int'(grant)*LEN_WIDTH +: LEN_WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      data_q   <= '0;
      active_q <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      burst_q  <= burst_d;
      data_q   <= data_d;
      active_q <= active_d;
      rr_q     <= rr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    burst_d  = burst_q;
    data_d   = data_q;
    active_d = active_q;
    rr_d     = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          src_d    = sel_src;
          dst_d    = sel_dst;
          len_d    = sel_len;
          burst_d  = '0;
          active_d = grant;
          // Zero-length requests complete without ever touching the bus.
          state_d  = (sel_len == '0) ? S_DONE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (!cpu_busy) state_d = S_READ;
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        data_d  = dataIn;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_d   = src_q + ADDR_WIDTH'(1);
        dst_d   = dst_q + ADDR_WIDTH'(1);
        len_d   = len_q - LEN_WIDTH'(1);
        burst_d = burst_q + BurstW'(1);
        if (len_q == LEN_WIDTH'(1))                 state_d = S_DONE;
        else if (32'(burst_q) + 32'd1 == BURST)     state_d = S_RELEASE;
        else                                        state_d = S_READ;
      end
      S_RELEASE: begin
        burst_d = '0;
        state_d = S_HOLD;
      end
      S_DONE: begin
        rr_d    = 3'((32'(active_q) + 32'd1) % NUM_CH);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_hold  = (state_q == S_HOLD) || (state_q == S_READ) ||
                (state_q == S_LATCH) || (state_q == S_WRITE);
    bus_own   = (state_q == S_READ) || (state_q == S_LATCH) || (state_q == S_WRITE);
    write     = (state_q == S_WRITE);
    address   = '0;
    dataOut   = '0;
    if (state_q == S_READ)  address = src_q;
    if (state_q == S_WRITE) begin
      address = dst_q;
      dataOut = data_q;
    end
    active_ch = active_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_done[i] = (state_q == S_DONE) && (32'(active_q) == i);
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Scoreboard bench for bus_dma: expected writes/done pulses are queued at stimulus
// time and a negedge monitor pops and compares them as the DUT produces them.
module tb_bus_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_req;
  logic [63:0] ch_src, ch_dst;
  logic [31:0] ch_len;
  logic [3:0]  ch_done;
  logic        cpu_hold, cpu_busy, bus_own, write;
  logic [15:0] address, dataOut, rdata;
  logic [2:0]  active_ch;

  always #5 clk = ~clk;

  bus_dma #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .LEN_WIDTH (8),
    .NUM_CH    (4),
    .BURST     (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_req   (ch_req),
    .ch_src   (ch_src),
    .ch_dst   (ch_dst),
    .ch_len   (ch_len),
    .ch_done  (ch_done),
    .cpu_hold (cpu_hold),
    .cpu_busy (cpu_busy),
    .bus_own  (bus_own),
    .address  (address),
    .dataIn   (rdata),
    .dataOut  (dataOut),
    .write    (write),
    .active_ch(active_ch)
  );

  // Synchronous RAM: read data appears one cycle after the address.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    rdata <= mem[address];
    if (write) mem[address] = dataOut;
  end

  typedef struct packed {
    logic        kind;  // 0 write, 1 done
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  ch;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          wcnt, last_w, done_cyc;
  logic        any_hold;
  int          low_at[$];
  logic [15:0] rd_addr[$];
  logic [3:0]  reraise;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_w(input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e = '{kind: 1'b0, addr: a, data: d, ch: 2'd0};
    sbq.push_back(e);
  endtask

  task automatic push_d(input logic [1:0] c);
    exp_t e;
    e = '{kind: 1'b1, addr: 16'h0, data: 16'h0, ch: c};
    sbq.push_back(e);
  endtask

  task automatic set_ch(input int c, input logic [15:0] s, input logic [15:0] d,
                        input logic [7:0] l);
    ch_src[c*16 +: 16] = s;
    ch_dst[c*16 +: 16] = d;
    ch_len[c*8 +: 8]   = l;
  endtask

  // Monitor: compares every write strobe and done pulse against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (!bus_own) chk("idle_bus_zero", 32'((address != 0) || (dataOut != 0) || write), 0);
      if (write) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual addr=%h data=%h required none", address, dataOut);
        end else begin
          e = sbq.pop_front();
          chk("sb_write_kind", 32'(e.kind), 0);
          chk("sb_write_addr", 32'(address), 32'(e.addr));
          chk("sb_write_data", 32'(dataOut), 32'(e.data));
        end
      end
      if (ch_done != 0) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=%b required none", ch_done);
        end else begin
          e = sbq.pop_front();
          chk("sb_done_kind", 32'(e.kind), 1);
          chk("sb_done_ch", 32'(ch_done), 32'(4'b0001 << e.ch));
        end
      end
    end
  end

  // Runs until the queue drains and all requests are retired, dropping ch_req on done.
  task automatic run(input int budget);
    int   n;
    logic started, prev_rd;
    n = 0; started = 0; prev_rd = 0;
    wcnt = 0; last_w = -1; done_cyc = -1; any_hold = 0;
    low_at.delete(); rd_addr.delete();
    while ((sbq.size() != 0 || ch_req != 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (cpu_hold) begin any_hold = 1; started = 1; end
      if (write) begin wcnt++; last_w = n; end
      if (bus_own && !write && !prev_rd) rd_addr.push_back(address);
      prev_rd = bus_own && !write;
      if (ch_done != 0) begin
        done_cyc = n;
        started  = 0;
        ch_req   = ch_req & ~ch_done;
        if (ch_done[1]) ch_req = ch_req | reraise;
      end else if (started && !cpu_hold) begin
        low_at.push_back(wcnt);
      end
    end
    chk("run_timeout", 32'(sbq.size() != 0 || ch_req != 0), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
    chk({tag, "_bus_own"}, 32'(bus_own), 0);
    chk({tag, "_write"}, 32'(write), 0);
    chk({tag, "_address"}, 32'(address), 0);
    chk({tag, "_dataOut"}, 32'(dataOut), 0);
    chk({tag, "_ch_done"}, 32'(ch_done), 0);
    chk({tag, "_active_ch"}, 32'(active_ch), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [15:0] exp_mem [3];
    reset = 1'b0; ch_req = '0; ch_src = '0; ch_dst = '0; ch_len = '0;
    cpu_busy = 1'b0; reraise = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0100] = 16'hAAAA; mem[16'h0101] = 16'hBBBB; mem[16'h0102] = 16'hCCCC;
    mem[16'h0300] = 16'h1234;
    for (int k = 0; k < 5; k++) mem[16'h0500 + k] = 16'h5001 + 16'(k);
    mem[16'hFFFF] = 16'hF00D; mem[16'h0000] = 16'h0BAD;
    for (int i = 0; i < 4; i++) mem[16'h1000 + 16'(i * 256)] = 16'hA000 + 16'(i);
    for (int k = 0; k < 4; k++) mem[16'h0800 + k] = 16'h8001 + 16'(k);

    #1;
    chk_outputs_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_hold", 32'(cpu_hold), 0);

    // Single copy, ch0
    set_ch(0, 16'h0100, 16'h0200, 8'd3);
    push_w(16'h0200, 16'hAAAA); push_w(16'h0201, 16'hBBBB); push_w(16'h0202, 16'hCCCC);
    push_d(2'd0);
    ch_req = 4'b0001;
    run(200);
    chk("single_write_count", 32'(wcnt), 3);
    chk("single_done_latency", 32'(done_cyc - last_w), 1);
    chk("single_hold_after", 32'(cpu_hold), 0);
    exp_mem[0] = 16'hAAAA; exp_mem[1] = 16'hBBBB; exp_mem[2] = 16'hCCCC;
    for (int k = 0; k < 3; k++) chk("single_mem", 32'(mem[16'h0200 + k]), 32'(exp_mem[k]));

    // Hold/busy handshake, ch1
    set_ch(1, 16'h0300, 16'h0400, 8'd1);
    push_w(16'h0400, 16'h1234); push_d(2'd1);
    cpu_busy = 1'b1;
    ch_req = 4'b0010;
    n = 0;
    while (!cpu_hold && n < 20) begin @(negedge clk); n++; end
    chk("hs_hold_rise", 32'(cpu_hold), 1);
    repeat (10) begin
      chk("hs_bus_own", 32'(bus_own), 0);
      chk("hs_address", 32'(address), 0);
      @(negedge clk);
    end
    cpu_busy = 1'b0;
    @(negedge clk);
    chk("hs_read_own", 32'(bus_own), 1);
    chk("hs_read_addr", 32'(address), 32'h0300);
    run(100);

    // Burst release with BURST=2, len=5, ch2
    set_ch(2, 16'h0500, 16'h0600, 8'd5);
    for (int k = 0; k < 5; k++) push_w(16'h0600 + 16'(k), 16'h5001 + 16'(k));
    push_d(2'd2);
    ch_req = 4'b0100;
    run(200);
    chk("burst_writes", 32'(wcnt), 5);
    chk("burst_release_count", 32'(low_at.size()), 2);
    chk("burst_release_0", (low_at.size() > 0) ? 32'(low_at[0]) : 32'hFFFF_FFFF, 2);
    chk("burst_release_1", (low_at.size() > 1) ? 32'(low_at[1]) : 32'hFFFF_FFFF, 4);
    chk("burst_mem_last", 32'(mem[16'h0604]), 32'h5005);

    // Source address wrap, ch3
    set_ch(3, 16'hFFFF, 16'h0700, 8'd2);
    push_w(16'h0700, 16'hF00D); push_w(16'h0701, 16'h0BAD); push_d(2'd3);
    ch_req = 4'b1000;
    run(100);
    chk("wrap_read_0", (rd_addr.size() > 0) ? 32'(rd_addr[0]) : 32'hFFFF_FFFF, 32'hFFFF);
    chk("wrap_read_1", (rd_addr.size() > 1) ? 32'(rd_addr[1]) : 32'hFFFF_FFFF, 32'h0000);

    // Round-robin: all four together, pointer at 0
    for (int i = 0; i < 4; i++) begin
      set_ch(i, 16'h1000 + 16'(i * 256), 16'h2000 + 16'(i * 256), 8'd1);
      push_w(16'h2000 + 16'(i * 256), 16'hA000 + 16'(i));
      push_d(2'(i));
    end
    ch_req = 4'b1111;
    run(300);

    // ch0+ch1, then ch0+ch2 re-raised on ch1's done: expect 0, 1, 2, 0
    push_w(16'h2000, 16'hA000); push_d(2'd0);
    push_w(16'h2100, 16'hA001); push_d(2'd1);
    push_w(16'h2200, 16'hA002); push_d(2'd2);
    push_w(16'h2000, 16'hA000); push_d(2'd0);
    reraise = 4'b0101;
    ch_req = 4'b0011;
    run(300);
    reraise = 4'b0000;

    // Zero length on ch1: done pulse, no hold
    set_ch(1, 16'h0300, 16'h0400, 8'd0);
    push_d(2'd1);
    ch_req = 4'b0010;
    run(50);
    chk("len0_no_hold", 32'(any_hold), 0);
    chk("len0_no_write", 32'(wcnt), 0);

    // Asynchronous reset in the middle of a WRITE
    set_ch(0, 16'h0800, 16'h0900, 8'd4);
    push_w(16'h0900, 16'h8001);
    ch_req = 4'b0001;
    n = 0;
    while (!write && n < 50) begin @(negedge clk); n++; end
    chk("rst_write_seen", 32'(write), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    ch_req = 4'b0000;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_queue_empty", 32'(sbq.size()), 0);
    chk("rst_mem_untouched", 32'(mem[16'h0900]), 0);

    set_ch(0, 16'h0800, 16'h0900, 8'd2);
    push_w(16'h0900, 16'h8001); push_w(16'h0901, 16'h8002); push_d(2'd0);
    ch_req = 4'b0001;
    run(100);
    chk("post_rst_mem", 32'(mem[16'h0901]), 32'h8002);
    chk("post_rst_no_extra", 32'(mem[16'h0902]), 0);
    chk("final_queue_empty", 32'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
